// File: rtl/rx_frame_ctrl.sv
// Four-lane receive framing controller: deskews lane bytes into 32-bit symbol
// words, acquires COM lock and frames packets between STP and END.
module rx_frame_ctrl #(
   parameter int SKEW_MAX   = 4,
   parameter int COM_NEEDED = 1,
   parameter int MAX_WORDS  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enb,
   input  logic [7:0]  lane_byte0,
   input  logic [7:0]  lane_byte1,
   input  logic [7:0]  lane_byte2,
   input  logic [7:0]  lane_byte3,
   input  logic [3:0]  lane_vld,
   output logic [31:0] data,
   output logic        data_vld,
   output logic        sop,
   output logic        eop,
   output logic        err,
   output logic        lock,
   output logic [3:0]  S
);

   localparam logic [1:0] HUNT      = 2'd0;
   localparam logic [1:0] LINK_IDLE = 2'd1;
   localparam logic [1:0] PKT       = 2'd2;

   localparam logic [7:0] K_COM  = 8'hBC;
   localparam logic [7:0] K_STP  = 8'hFB;
   localparam logic [7:0] K_END  = 8'hFD;
   localparam logic [7:0] K_IDLE = 8'h00;

   localparam int SKW = $clog2(SKEW_MAX + 1) + 1;

   logic [7:0]     in_byte [4];
   logic [7:0]     hold [4];
   logic [3:0]     s_hold;
   logic [SKW-1:0] skew_cnt;
   logic [31:0]    sym_word;
   logic           sym_vld;
   logic           skew_err;

   logic [3:0]     avail;
   logic           complete;
   logic           dbl;
   logic           tmo;
   logic [31:0]    sym_next;

   logic [1:0]     state;
   logic [3:0]     com_cnt;
   logic [6:0]     word_cnt;
   logic           sop_armed;
   logic [31:0]    data_q;
   logic           data_vld_q;
   logic           sop_q;
   logic           eop_q;
   logic           err_q;

   logic [7:0]     b0;
   logic           all_eq;
   logic           is_com;
   logic           is_stp;
   logic           is_end;
   logic           is_idle;
   logic           is_data;

   assign in_byte[0] = lane_byte0;
   assign in_byte[1] = lane_byte1;
   assign in_byte[2] = lane_byte2;
   assign in_byte[3] = lane_byte3;

   // Completion has priority over both skew errors, so a late lane that still
   // completes the symbol on the timeout cycle is accepted.
   always_comb begin
      avail    = s_hold | lane_vld;
      complete = (&avail) && (|lane_vld);
      dbl      = (|(lane_vld & s_hold)) && !complete;
      tmo      = (s_hold != 4'd0) && (skew_cnt == SKW'(SKEW_MAX)) && !complete;
      sym_next = '0;
      for (int i = 0; i < 4; i++) begin
         sym_next[8*i +: 8] = s_hold[i] ? hold[i] : in_byte[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_hold   <= '0;
         skew_cnt <= '0;
         sym_word <= '0;
         sym_vld  <= 1'b0;
         skew_err <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            hold[i] <= '0;
         end
      end else if (enb) begin
         sym_vld  <= 1'b0;
         skew_err <= 1'b0;
         if (complete) begin
            s_hold   <= '0;
            skew_cnt <= '0;
            sym_word <= sym_next;
            sym_vld  <= 1'b1;
         end else if (dbl || tmo) begin
            s_hold   <= '0;
            skew_cnt <= '0;
            skew_err <= 1'b1;
         end else begin
            s_hold   <= avail;
            skew_cnt <= (avail != 4'd0) ? skew_cnt + SKW'(1) : '0;
            for (int i = 0; i < 4; i++) begin
               if (lane_vld[i]) hold[i] <= in_byte[i];
            end
         end
      end
   end

   always_comb begin
      b0      = sym_word[7:0];
      all_eq  = (sym_word == {4{b0}});
      is_com  = all_eq && (b0 == K_COM);
      is_stp  = all_eq && (b0 == K_STP);
      is_end  = all_eq && (b0 == K_END);
      is_idle = all_eq && (b0 == K_IDLE);
      is_data = !(is_com || is_stp || is_end || is_idle);
   end

   // Framing FSM runs one stage behind assembly, so every strobe appears one
   // cycle after the symbol completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HUNT;
         com_cnt    <= '0;
         word_cnt   <= '0;
         sop_armed  <= 1'b0;
         data_q     <= '0;
         data_vld_q <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
      end else if (!enb) begin
         data_vld_q <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         data_vld_q <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
         if (skew_err) begin
            err_q   <= 1'b1;
            state   <= HUNT;
            com_cnt <= '0;
         end else if (sym_vld) begin
            case (state)
               HUNT: begin
                  if (is_com) begin
                     if (com_cnt + 4'd1 == 4'(COM_NEEDED)) begin
                        state   <= LINK_IDLE;
                        com_cnt <= '0;
                     end else begin
                        com_cnt <= com_cnt + 4'd1;
                     end
                  end else begin
                     com_cnt <= '0;
                  end
               end
               LINK_IDLE: begin
                  if (is_stp) begin
                     state     <= PKT;
                     word_cnt  <= '0;
                     sop_armed <= 1'b1;
                  end else if (!(is_idle || is_com)) begin
                     err_q <= 1'b1;
                     state <= HUNT;
                  end
               end
               PKT: begin
                  if (is_data) begin
                     if (word_cnt == 7'(MAX_WORDS)) begin
                        err_q     <= 1'b1;
                        sop_armed <= 1'b0;
                        state     <= LINK_IDLE;
                     end else begin
                        data_q     <= sym_word;
                        data_vld_q <= 1'b1;
                        sop_q      <= sop_armed;
                        sop_armed  <= 1'b0;
                        word_cnt   <= word_cnt + 7'd1;
                     end
                  end else if (is_end) begin
                     eop_q <= 1'b1;
                     err_q <= (word_cnt == 7'd0);
                     state <= LINK_IDLE;
                  end else begin
                     eop_q <= 1'b1;
                     err_q <= 1'b1;
                     state <= is_com ? HUNT : LINK_IDLE;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   assign data     = data_q;
   assign data_vld = data_vld_q & enb;
   assign sop      = sop_q & enb;
   assign eop      = eop_q & enb;
   assign err      = err_q & enb;
   assign lock     = (state == LINK_IDLE) || (state == PKT);
   assign S        = s_hold;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: directed symbol streams push expected
// strobe events, a negedge monitor pops and compares them.
module tb_rx_frame_ctrl;

   localparam logic [31:0] W_COM  = 32'hBCBCBCBC;
   localparam logic [31:0] W_STP  = 32'hFBFBFBFB;
   localparam logic [31:0] W_END  = 32'hFDFDFDFD;
   localparam logic [31:0] W_IDLE = 32'h00000000;

   logic        clk;
   logic        reset;
   logic        enb;
   logic [7:0]  lane_byte0;
   logic [7:0]  lane_byte1;
   logic [7:0]  lane_byte2;
   logic [7:0]  lane_byte3;
   logic [3:0]  lane_vld;
   logic [31:0] data;
   logic        data_vld;
   logic        sop;
   logic        eop;
   logic        err;
   logic        lock;
   logic [3:0]  S;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    assertions = 0;
   int    failures   = 0;

   rx_frame_ctrl #(.SKEW_MAX(4), .COM_NEEDED(1), .MAX_WORDS(2)) dut (
      .clk(clk), .reset(reset), .enb(enb),
      .lane_byte0(lane_byte0), .lane_byte1(lane_byte1),
      .lane_byte2(lane_byte2), .lane_byte3(lane_byte3),
      .lane_vld(lane_vld), .data(data), .data_vld(data_vld), .sop(sop),
      .eop(eop), .err(err), .lock(lock), .S(S)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      assertions++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // flags are {data_vld, sop, eop, err}
   task automatic expect_evt(input string name, input logic [31:0] d, input logic [3:0] f);
      exp_t e;
      e.data  = d;
      e.flags = f;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   task automatic apply_stimulus(input logic [3:0] v, input logic [31:0] w);
      {lane_byte3, lane_byte2, lane_byte1, lane_byte0} = w;
      lane_vld = v;
      @(posedge clk);
      #1;
      lane_vld = 4'h0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string nm;
      if (data_vld || eop || err) begin
         assertions++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_output: got vld=%b sop=%b eop=%b err=%b data=%h, required no output",
                     data_vld, sop, eop, err, data);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({data_vld, sop, eop, err} !== e.flags || (e.flags[3] && data !== e.data)) begin
               failures++;
               $display("[TB] FAIL %s: got vld/sop/eop/err=%b data=%h, required %b data=%h",
                        nm, {data_vld, sop, eop, err}, data, e.flags, e.data);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      enb        = 1'b1;
      lane_vld   = 4'h0;
      lane_byte0 = 8'h00;
      lane_byte1 = 8'h00;
      lane_byte2 = 8'h00;
      lane_byte3 = 8'h00;
      idle_cycles(2);
      check_output("reset_data", data, 32'h0);
      check_output("reset_strobes", {28'h0, data_vld, sop, eop, err}, 32'h0);
      check_output("reset_lock", {31'h0, lock}, 32'h0);
      check_output("reset_S", {28'h0, S}, 32'h0);
      reset = 1'b0;

      // Lock acquisition
      apply_stimulus(4'hF, W_IDLE);
      apply_stimulus(4'hF, W_COM);
      check_output("com_S_clear", {28'h0, S}, 32'h0);
      check_output("lock_not_yet", {31'h0, lock}, 32'h0);
      idle_cycles(1);
      check_output("lock_after_com", {31'h0, lock}, 32'h1);

      // Two-word packet
      expect_evt("pkt_word0", 32'h03020100, 4'b1100);
      expect_evt("pkt_word1", 32'h07060504, 4'b1000);
      expect_evt("pkt_eop", 32'h0, 4'b0010);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, 32'h03020100);
      apply_stimulus(4'hF, 32'h07060504);
      apply_stimulus(4'hF, W_END);
      idle_cycles(2);

      // Staggered lanes within the skew window
      expect_evt("skew_word", 32'h0B0A0908, 4'b1100);
      expect_evt("skew_eop", 32'h0, 4'b0010);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'h1, 32'h0B0A0908);
      check_output("skew_S_0001", {28'h0, S}, 32'h1);
      apply_stimulus(4'h2, 32'h0B0A0908);
      check_output("skew_S_0011", {28'h0, S}, 32'h3);
      apply_stimulus(4'h4, 32'h0B0A0908);
      check_output("skew_S_0111", {28'h0, S}, 32'h7);
      apply_stimulus(4'h8, 32'h0B0A0908);
      check_output("skew_S_0000", {28'h0, S}, 32'h0);
      apply_stimulus(4'hF, W_END);
      idle_cycles(2);

      // Completion on the timeout cycle is accepted
      expect_evt("edge_word", 32'h0F0E0D0C, 4'b1100);
      expect_evt("edge_eop", 32'h0, 4'b0010);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'h1, 32'h0F0E0D0C);
      idle_cycles(3);
      apply_stimulus(4'hE, 32'h0F0E0D0C);
      check_output("edge_S_clear", {28'h0, S}, 32'h0);
      apply_stimulus(4'hF, W_END);
      idle_cycles(2);

      // Skew timeout: last lane never arrives in time
      expect_evt("tmo_err", 32'h0, 4'b0001);
      apply_stimulus(4'h1, 32'h13121110);
      idle_cycles(3);
      check_output("tmo_S_pending", {28'h0, S}, 32'h1);
      idle_cycles(1);
      check_output("tmo_S_cleared", {28'h0, S}, 32'h0);
      check_output("tmo_lock_before", {31'h0, lock}, 32'h1);
      idle_cycles(1);
      check_output("tmo_lock_drop", {31'h0, lock}, 32'h0);

      // Double byte on one lane
      apply_stimulus(4'hF, W_COM);
      idle_cycles(1);
      check_output("relock1", {31'h0, lock}, 32'h1);
      expect_evt("dbl_err", 32'h0, 4'b0001);
      apply_stimulus(4'h1, 32'h17161514);
      check_output("dbl_S_first", {28'h0, S}, 32'h1);
      apply_stimulus(4'h1, 32'h17161514);
      check_output("dbl_S_clear", {28'h0, S}, 32'h0);
      idle_cycles(1);
      check_output("dbl_lock_drop", {31'h0, lock}, 32'h0);

      // Empty packet
      apply_stimulus(4'hF, W_COM);
      expect_evt("empty_eop_err", 32'h0, 4'b0011);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, W_END);
      idle_cycles(2);
      check_output("empty_lock_kept", {31'h0, lock}, 32'h1);

      // COM inside a packet
      expect_evt("com_pkt_word", 32'h11223344, 4'b1100);
      expect_evt("com_pkt_eop_err", 32'h0, 4'b0011);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, 32'h11223344);
      apply_stimulus(4'hF, W_COM);
      check_output("com_pkt_lock_before", {31'h0, lock}, 32'h1);
      idle_cycles(1);
      check_output("com_pkt_lock_drop", {31'h0, lock}, 32'h0);

      // Packet overflow beyond two words
      apply_stimulus(4'hF, W_COM);
      expect_evt("ovf_word0", 32'h21222324, 4'b1100);
      expect_evt("ovf_word1", 32'h31323334, 4'b1000);
      expect_evt("ovf_err", 32'h0, 4'b0001);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, 32'h21222324);
      apply_stimulus(4'hF, 32'h31323334);
      apply_stimulus(4'hF, 32'h41424344);
      idle_cycles(2);
      check_output("ovf_lock_kept", {31'h0, lock}, 32'h1);

      // Enable dropped mid-packet
      expect_evt("enb_word0", 32'h51525354, 4'b1100);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, 32'h51525354);
      enb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(4'hF, 32'h61626364);
         check_output("enb_low_S", {28'h0, S}, 32'h0);
         check_output("enb_low_strobes", {28'h0, data_vld, sop, eop, err}, 32'h0);
      end
      check_output("enb_low_lock", {31'h0, lock}, 32'h1);
      enb = 1'b1;
      expect_evt("enb_word1", 32'h71727374, 4'b1000);
      expect_evt("enb_eop", 32'h0, 4'b0010);
      apply_stimulus(4'hF, 32'h71727374);
      apply_stimulus(4'hF, W_END);
      idle_cycles(2);

      // Reset mid-packet
      expect_evt("rst_word", 32'h81828384, 4'b1100);
      apply_stimulus(4'hF, W_STP);
      apply_stimulus(4'hF, 32'h81828384);
      idle_cycles(1);
      reset = 1'b1;
      idle_cycles(1);
      check_output("rst_data", data, 32'h0);
      check_output("rst_strobes", {28'h0, data_vld, sop, eop, err}, 32'h0);
      check_output("rst_lock", {31'h0, lock}, 32'h0);
      check_output("rst_S", {28'h0, S}, 32'h0);
      reset = 1'b0;
      idle_cycles(3);

      check_output("scoreboard_drained", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
